// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry, stream record and paddle FSM state type
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CALC   = 2'd2,
    MOVE   = 2'd3
  } paddle_state_t;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_bus_t;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing and pixel stream bundle
interface vga_if;

  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface

// File: rtl/paddle_motion.sv
// rtl/paddle_motion.sv - per-frame paddle position update: tick detect, FSM, target and slew limit
module paddle_motion import vga_pkg::*; #(
  parameter int HEIGHT = 100,
  parameter int STEP   = 16,
  parameter int SCALE  = 3,
  parameter int OFFSET = 40,
  parameter int LO_TH  = 20,
  parameter int HI_TH  = 235,
  parameter int Y_INIT = (VER_PIXELS - HEIGHT) / 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic        mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [8:0]  pos,
  input  logic [8:0]  pos_second,
  output logic [10:0] y_position
);

  localparam logic [10:0] Y_MAX_L = 11'(VER_PIXELS - HEIGHT);
  localparam logic [10:0] STEP_L  = 11'(STEP);

  paddle_state_t state_q, state_d;
  logic        vblnk_q, vblnk_d;
  logic        armed_q, armed_d;
  logic        mode_q, mode_d, up_q, up_d, dn_q, dn_d;
  logic [8:0]  pos_q, pos_d, pos2_q, pos2_d;
  logic [10:0] target_q, target_d;
  logic [10:0] y_q, y_d;

  logic               tick;
  logic [8:0]         pmin;
  logic signed [12:0] lin;
  logic [10:0]        trk_target, btn_target, y_next;

  always_comb begin
    // armed_q marks vblnk_q as a real sample, so a release during vblank is not a tick
    tick = vblnk & ~vblnk_q & armed_q;

    pmin = (pos_q < pos2_q) ? pos_q : pos2_q;
    lin  = $signed({4'b0, pmin} * 13'(SCALE)) - $signed(13'(OFFSET));
    if (pos_q < 9'(LO_TH) && pos2_q < 9'(LO_TH))
      trk_target = '0;
    else if (pos_q >= 9'(HI_TH) || pos2_q >= 9'(HI_TH))
      trk_target = Y_MAX_L;
    else if (lin < 13'sd0)
      trk_target = '0;
    else if (lin > $signed({2'b00, Y_MAX_L}))
      trk_target = Y_MAX_L;
    else
      trk_target = lin[10:0];

    if (up_q && !dn_q)
      btn_target = (y_q < STEP_L) ? 11'd0 : y_q - STEP_L;
    else if (dn_q && !up_q)
      btn_target = ({1'b0, y_q} + {1'b0, STEP_L} > {1'b0, Y_MAX_L}) ? Y_MAX_L : y_q + STEP_L;
    else
      btn_target = y_q;

    if (target_q >= y_q)
      y_next = (target_q - y_q <= STEP_L) ? target_q : y_q + STEP_L;
    else
      y_next = (y_q - target_q <= STEP_L) ? target_q : y_q - STEP_L;

    state_d  = state_q;
    vblnk_d  = vblnk;
    armed_d  = 1'b1;
    mode_d   = mode_q;
    up_d     = up_q;
    dn_d     = dn_q;
    pos_d    = pos_q;
    pos2_d   = pos2_q;
    target_d = target_q;
    y_d      = y_q;

    case (state_q)
      IDLE: if (tick) state_d = SAMPLE;
      SAMPLE: begin
        mode_d  = mode;
        up_d    = btn_up;
        dn_d    = btn_down;
        pos_d   = pos;
        pos2_d  = pos_second;
        state_d = CALC;
      end
      CALC: begin
        target_d = mode_q ? btn_target : trk_target;
        state_d  = MOVE;
      end
      MOVE: begin
        y_d     = y_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vblnk_q  <= 1'b0;
      armed_q  <= 1'b0;
      mode_q   <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      pos_q    <= '0;
      pos2_q   <= '0;
      target_q <= '0;
      y_q      <= 11'(Y_INIT);
    end else begin
      state_q  <= state_d;
      vblnk_q  <= vblnk_d;
      armed_q  <= armed_d;
      mode_q   <= mode_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      pos_q    <= pos_d;
      pos2_q   <= pos2_d;
      target_q <= target_d;
      y_q      <= y_d;
    end
  end

  assign y_position = y_q;

endmodule

// File: rtl/draw_paddle.sv
// rtl/draw_paddle.sv - overlays a solid paddle on the VGA stream with a one-cycle pipeline
module draw_paddle import vga_pkg::*; #(
  parameter int          X_POS  = 30,
  parameter int          WIDTH  = 15,
  parameter int          HEIGHT = 100,
  parameter logic [11:0] COLOR  = 12'hFFF,
  parameter int          STEP   = 16,
  parameter int          SCALE  = 3,
  parameter int          OFFSET = 40,
  parameter int          LO_TH  = 20,
  parameter int          HI_TH  = 235,
  parameter int          Y_INIT = (VER_PIXELS - HEIGHT) / 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [8:0]  pos,
  input  logic [8:0]  pos_second,
  output logic [10:0] y_position,
  vga_if.in           vga,
  vga_if.out          vga_out
);

  vga_bus_t bus_q, bus_d;
  logic     in_x, in_y, draw;

  paddle_motion #(
    .HEIGHT(HEIGHT), .STEP(STEP), .SCALE(SCALE), .OFFSET(OFFSET),
    .LO_TH(LO_TH), .HI_TH(HI_TH), .Y_INIT(Y_INIT)
  ) u_motion (
    .clk        (clk),
    .rst_n      (rst_n),
    .vblnk      (vga.vblnk),
    .mode       (mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .pos        (pos),
    .pos_second (pos_second),
    .y_position (y_position)
  );

  always_comb begin
    in_x = ({1'b0, vga.hcount} >= 12'(X_POS)) && ({1'b0, vga.hcount} < 12'(X_POS + WIDTH));
    in_y = ({1'b0, vga.vcount} >= {1'b0, y_position}) &&
           ({1'b0, vga.vcount} < {1'b0, y_position} + 12'(HEIGHT));
    draw = in_x && in_y && !vga.hblnk && !vga.vblnk;

    bus_d.vcount = vga.vcount;
    bus_d.vsync  = vga.vsync;
    bus_d.vblnk  = vga.vblnk;
    bus_d.hcount = vga.hcount;
    bus_d.hsync  = vga.hsync;
    bus_d.hblnk  = vga.hblnk;
    bus_d.rgb    = draw ? COLOR : vga.rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_q <= '0;
    else        bus_q <= bus_d;
  end

  assign vga_out.vcount = bus_q.vcount;
  assign vga_out.vsync  = bus_q.vsync;
  assign vga_out.vblnk  = bus_q.vblnk;
  assign vga_out.hcount = bus_q.hcount;
  assign vga_out.hsync  = bus_q.hsync;
  assign vga_out.hblnk  = bus_q.hblnk;
  assign vga_out.rgb    = bus_q.rgb;

endmodule
